// File: rtl/barvinn_pkg.sv
// Shared BARVINN loader types: transfer targets, loader FSM states and
// command-stream header field positions.
package barvinn_pkg;

  typedef enum logic [1:0] {
    LD_IMEM   = 2'd0,
    LD_DMEM   = 2'd1,
    LD_WEIGHT = 2'd2,
    LD_RSVD   = 2'd3
  } ld_target_e;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_HDR1 = 2'd1,
    LS_DATA = 2'd2,
    LS_DONE = 2'd3
  } ld_state_e;

  localparam int BEAT_W     = 32;
  localparam int H0_TGT_HI  = 31;
  localparam int H0_TGT_LO  = 30;
  localparam int H0_MASK_LO = 0;
  localparam int H1_BASE_LO = 0;
  localparam int H1_LEN_HI  = 31;
  localparam int H1_LEN_LO  = 16;

  function automatic logic is_pito_target(input ld_target_e t);
    return (t == LD_IMEM) || (t == LD_DMEM);
  endfunction

endpackage

// File: rtl/ldr_word_packer.sv
// Collects 32-bit beats, least-significant first, into one WWORD word and
// flags the beat that completes it. A partial word survives idle cycles.
module ldr_word_packer
  import barvinn_pkg::*;
#(
  parameter int WWORD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [31:0]       beat_data,
  output logic              word_valid,
  output logic [WWORD-1:0]  word
);

  localparam int BPW = WWORD / BEAT_W;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] cnt;

  assign word_valid = beat_valid && (cnt == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (beat_valid) begin
      cnt <= word_valid ? '0 : cnt + CW'(1);
    end
  end

  generate
    if (BPW == 1) begin : g_single
      assign word = beat_data;
    end else begin : g_multi
      // Earlier beats of the word; the completing beat is taken straight
      // from the input so the word is ready on the same cycle.
      logic [WWORD-BEAT_W-1:0] sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else if (beat_valid && !word_valid) begin
          sr[int'(cnt)*BEAT_W +: BEAT_W] <= beat_data;
        end
      end

      assign word = {beat_data, sr};
    end
  endgenerate

endmodule

// File: rtl/barvinn_host_loader.sv
// Host command-stream loader: decodes H0/H1 headers and turns data beats into
// auto-incrementing pito imem/dmem writes or broadcast MVU weight writes.
module barvinn_host_loader
  import barvinn_pkg::*;
#(
  parameter int NMVU  = 8,
  parameter int IADDR = 12,
  parameter int WADDR = 9,
  parameter int WWORD = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    pito_program,
  output logic                    pito_imem_w_en,
  output logic                    pito_dmem_w_en,
  output logic [IADDR-1:0]        pito_mem_addr,
  output logic [31:0]             pito_mem_data,
  output logic [NMVU-1:0]         mvu_wrw_en,
  output logic [NMVU*WADDR-1:0]   mvu_wrw_addr,
  output logic [NMVU*WWORD-1:0]   mvu_wrw_word,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  localparam int AW = (IADDR > WADDR) ? IADDR : WADDR;

  ld_state_e         state, state_next;
  ld_target_e        tgt_q;
  logic [NMVU-1:0]   mask_q;
  logic [AW-1:0]     addr_q;
  logic [15:0]       len_q;
  logic [15:0]       idx_q;
  logic              bad_q;
  logic [WADDR-1:0]  mvu_addr_q;
  logic [WWORD-1:0]  mvu_word_q;

  logic              beat;
  logic              data_beat;
  logic              pk_beat;
  logic              pk_word_valid;
  logic [WWORD-1:0]  pk_word;
  logic              word_done;
  logic              last_word;
  logic              hdr_bad;

  // Handshake: a beat transfers on any cycle where s_valid && s_ready are
  // both high at the clock edge; the only back-pressure is the DONE cycle.
  assign s_ready   = !rst && (state != LS_DONE);
  assign beat      = s_valid && s_ready;
  assign data_beat = beat && (state == LS_DATA);
  assign pk_beat   = data_beat && (tgt_q == LD_WEIGHT);
  assign word_done = data_beat && ((tgt_q == LD_WEIGHT) ? pk_word_valid : 1'b1);
  assign last_word = (idx_q == len_q);
  assign hdr_bad   = (tgt_q == LD_RSVD) || ((tgt_q == LD_WEIGHT) && (mask_q == '0));

  assign busy      = (state != LS_IDLE);
  assign dbg_state = state;

  assign mvu_wrw_addr = {NMVU{mvu_addr_q}};
  assign mvu_wrw_word = {NMVU{mvu_word_q}};

  ldr_word_packer #(
    .WWORD(WWORD)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != LS_DATA),
    .beat_valid (pk_beat),
    .beat_data  (s_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LS_IDLE: if (beat) state_next = LS_HDR1;
      LS_HDR1: if (beat) state_next = LS_DATA;
      LS_DATA: if (word_done && last_word) state_next = LS_DONE;
      LS_DONE: state_next = LS_IDLE;
      default: state_next = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q          <= LD_IMEM;
      mask_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      bad_q          <= 1'b0;
      pito_program   <= 1'b0;
      pito_imem_w_en <= 1'b0;
      pito_dmem_w_en <= 1'b0;
      pito_mem_addr  <= '0;
      pito_mem_data  <= '0;
      mvu_wrw_en     <= '0;
      mvu_addr_q     <= '0;
      mvu_word_q     <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      pito_imem_w_en <= 1'b0;
      pito_dmem_w_en <= 1'b0;
      mvu_wrw_en     <= '0;
      done           <= 1'b0;
      case (state)
        LS_IDLE: begin
          if (beat) begin
            tgt_q        <= ld_target_e'(s_data[H0_TGT_HI:H0_TGT_LO]);
            mask_q       <= s_data[H0_MASK_LO +: NMVU];
            pito_program <= is_pito_target(ld_target_e'(s_data[H0_TGT_HI:H0_TGT_LO]));
          end
        end
        LS_HDR1: begin
          if (beat) begin
            addr_q <= s_data[H1_BASE_LO +: AW];
            len_q  <= s_data[H1_LEN_HI:H1_LEN_LO];
            idx_q  <= '0;
            bad_q  <= hdr_bad;
            if (hdr_bad) err <= 1'b1;
          end
        end
        LS_DATA: begin
          if (word_done) begin
            // Rejected transfers still walk the full length, silently.
            idx_q  <= idx_q + 16'd1;
            addr_q <= addr_q + AW'(1);
            if (last_word) done <= 1'b1;
            if (!bad_q) begin
              case (tgt_q)
                LD_IMEM: begin
                  pito_imem_w_en <= 1'b1;
                  pito_mem_addr  <= addr_q[IADDR-1:0];
                  pito_mem_data  <= s_data;
                end
                LD_DMEM: begin
                  pito_dmem_w_en <= 1'b1;
                  pito_mem_addr  <= addr_q[IADDR-1:0];
                  pito_mem_data  <= s_data;
                end
                LD_WEIGHT: begin
                  mvu_wrw_en <= mask_q;
                  mvu_addr_q <= addr_q[WADDR-1:0];
                  mvu_word_q <= pk_word;
                end
                default: ;
              endcase
            end
          end
        end
        LS_DONE: pito_program <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barvinn_host_loader.sv
// Bench for barvinn_host_loader: directed table of transfers, hand-written
// gap/reset sequences and random transfers against a write-list model.
module tb_barvinn_host_loader;

  localparam int NMVU  = 8;
  localparam int IADDR = 12;
  localparam int WADDR = 9;
  localparam int WWORD = 64;
  localparam int EW    = 87;

  logic                   clk;
  logic                   rst;
  logic [31:0]            s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   pito_program;
  logic                   pito_imem_w_en;
  logic                   pito_dmem_w_en;
  logic [IADDR-1:0]       pito_mem_addr;
  logic [31:0]            pito_mem_data;
  logic [NMVU-1:0]        mvu_wrw_en;
  logic [NMVU*WADDR-1:0]  mvu_wrw_addr;
  logic [NMVU*WWORD-1:0]  mvu_wrw_word;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [1:0]             dbg_state;

  barvinn_host_loader #(
    .NMVU(NMVU), .IADDR(IADDR), .WADDR(WADDR), .WWORD(WWORD)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pito_program(pito_program), .pito_imem_w_en(pito_imem_w_en),
    .pito_dmem_w_en(pito_dmem_w_en), .pito_mem_addr(pito_mem_addr),
    .pito_mem_data(pito_mem_data), .mvu_wrw_en(mvu_wrw_en),
    .mvu_wrw_addr(mvu_wrw_addr), .mvu_wrw_word(mvu_wrw_word),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int wr_count = 0;
  logic exp_err = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   beats[$];

  // write record: {program, kind, enables, address, data}
  function automatic logic [EW-1:0] mk(input logic prog, input logic [1:0] kind,
                                       input logic [7:0] en, input logic [11:0] addr,
                                       input logic [63:0] data);
    return {prog, kind, en, addr, data};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input int gapmax);
    int g;
    int to;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin @(posedge clk); #1; end
    s_data  = d;
    s_valid = 1'b1;
    to = 0;
    while (s_ready !== 1'b1 && to < 50) begin @(posedge clk); #1; to++; end
    n_total++;
    if (to >= 50) begin
      n_bad++;
      $display("FAIL handshake_timeout actual=s_ready_low required=s_ready_high");
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  // Model: derive the full list of destination writes from the headers.
  task automatic do_xfer(input logic [31:0] h0, input logic [31:0] h1, input int gapmax);
    int tgt, len, base, nw, nb;
    logic [7:0] mask;
    logic bad;
    tgt  = int'(h0[31:30]);
    mask = h0[7:0];
    base = int'(h1[15:0]);
    len  = int'(h1[31:16]);
    nw   = len + 1;
    nb   = (tgt == 2) ? 2 * nw : nw;
    while (beats.size() < nb) beats.push_back($urandom);
    bad  = (tgt == 3) || (tgt == 2 && mask == 8'h00);
    if (!bad) begin
      for (int w = 0; w < nw; w++) begin
        if (tgt == 2)
          exp_q.push_back(mk(1'b0, 2'd2, mask, 12'((base + w) % 512),
                             {beats[2*w+1], beats[2*w]}));
        else
          exp_q.push_back(mk(1'b1, 2'(tgt), 8'h00, 12'((base + w) % 4096),
                             {32'h0, beats[w]}));
      end
    end
    exp_err = exp_err | bad;
    wr_count = 0;
    send_beat(h0, gapmax);
    send_beat(h1, gapmax);
    for (int i = 0; i < nb; i++) send_beat(beats[i], gapmax);
    beats.delete();
    chk("done_pulse", 64'(done), 64'd1);
    chk("ready_in_done", 64'(s_ready), 64'd0);
    chk("prog_in_done", 64'(pito_program), 64'(tgt < 2));
    @(posedge clk); #1;
    chk("done_drop", 64'(done), 64'd0);
    chk("busy_drop", 64'(busy), 64'd0);
    chk("prog_drop", 64'(pito_program), 64'd0);
    chk("ready_back", 64'(s_ready), 64'd1);
    chk("write_count", 64'(wr_count), bad ? 64'd0 : 64'(nw));
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("err_flag", 64'(err), 64'(exp_err));
  endtask

  // ---------------- scoreboard monitor ----------------
  int mon_nf;
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;
  logic mon_ok;
  always @(negedge clk) begin
    mon_nf = int'(pito_imem_w_en === 1'b1) + int'(pito_dmem_w_en === 1'b1) +
             int'(mvu_wrw_en !== 8'h00);
    if (mon_nf != 0) begin
      wr_count++;
      if (pito_imem_w_en === 1'b1)
        mon_act = mk(pito_program, 2'd0, 8'h00, pito_mem_addr, {32'h0, pito_mem_data});
      else if (pito_dmem_w_en === 1'b1)
        mon_act = mk(pito_program, 2'd1, 8'h00, pito_mem_addr, {32'h0, pito_mem_data});
      else
        mon_act = mk(pito_program, 2'd2, mvu_wrw_en, {3'b0, mvu_wrw_addr[WADDR-1:0]},
                     mvu_wrw_word[WWORD-1:0]);
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write actual=%0h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_ok = (mon_nf == 1) && (mon_act === mon_exp);
        if (mon_exp[85:84] == 2'd2) begin
          for (int c = 0; c < NMVU; c++) begin
            if (mvu_wrw_addr[c*WADDR +: WADDR] !== mon_exp[72:64]) mon_ok = 1'b0;
            if (mvu_wrw_word[c*WWORD +: WWORD] !== mon_exp[63:0]) mon_ok = 1'b0;
          end
        end
        if (!mon_ok) begin
          n_bad++;
          $display("FAIL write actual=%0h required=%0h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] h0;
    logic [31:0] h1;
    int          gap;
    int          exp_nwr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   r_tgt, r_len;
  logic [15:0] r_mask, r_base;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0002_0010, 0, 3, 1'b0};  // imem A,B,C at 0x10
    vecs[1] = '{32'h4000_0000, 32'h0001_0FFF, 1, 2, 1'b0};  // dmem wrap
    vecs[2] = '{32'h8000_FFFF, 32'h0002_0100, 2, 3, 1'b0};  // weight, all MVUs
    vecs[3] = '{32'h0000_0000, 32'h0003_0FFE, 0, 4, 1'b0};  // imem wrap
    vecs[4] = '{32'hC000_0000, 32'h0003_0000, 1, 0, 1'b1};  // reserved target
    vecs[5] = '{32'h0000_0000, 32'h0000_0123, 0, 1, 1'b1};  // normal after error
    vecs[6] = '{32'h8000_0000, 32'h0001_0000, 1, 0, 1'b1};  // weight mask 0
    vecs[7] = '{32'h8000_FF00, 32'h0000_0000, 0, 0, 1'b1};  // mask only above NMVU

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_prog", 64'(pito_program), 64'd0);
    chk("rst_wen", 64'({pito_imem_w_en, pito_dmem_w_en, mvu_wrw_en}), 64'd0);
    chk("rst_addr", 64'(pito_mem_addr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(s_ready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      do_xfer(vecs[v].h0, vecs[v].h1, vecs[v].gap);
      chk("tbl_nwr", 64'(wr_count), 64'(vecs[v].exp_nwr));
      chk("tbl_err", 64'(err), 64'(vecs[v].exp_err));
    end

    // weight broadcast to MVU 0 and 2 with idle gaps between beats
    beats.push_back(32'h1111_1111);
    beats.push_back(32'h2222_2222);
    do_xfer(32'h8000_0005, 32'h0000_01FF, 4);
    chk("bcast_word_ch0", mvu_wrw_word[0 +: 64], 64'h2222_2222_1111_1111);
    chk("bcast_word_ch2", mvu_wrw_word[128 +: 64], 64'h2222_2222_1111_1111);
    chk("bcast_addr_ch2", 64'(mvu_wrw_addr[18 +: 9]), 64'h1FF);

    // reset after one of two weight beats
    send_beat(32'h8000_0003, 0);
    send_beat(32'h0001_0040, 0);
    send_beat(32'hDEAD_BEEF, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_word", mvu_wrw_word[63:0], 64'd0);
    chk("mid_rst_maddr", 64'(mvu_wrw_addr[8:0]), 64'd0);
    chk("mid_rst_pdata", 64'(pito_mem_data), 64'd0);
    rst = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_ready_back", 64'(s_ready), 64'd1);
    beats.push_back(32'hAAAA_0001);
    beats.push_back(32'hBBBB_0002);
    beats.push_back(32'hCCCC_0003);
    beats.push_back(32'hDDDD_0004);
    do_xfer(32'h8000_0003, 32'h0001_0040, 0);
    chk("post_rst_word", mvu_wrw_word[63:0], 64'hDDDD_0004_CCCC_0003);
    chk("post_rst_addr", 64'(mvu_wrw_addr[8:0]), 64'h041);

    // random transfers
    for (int k = 0; k < 30; k++) begin
      r_tgt  = int'($urandom_range(3, 0));
      r_mask = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
      r_base = 16'($urandom);
      r_len  = int'($urandom_range(5, 0));
      do_xfer({2'(r_tgt), 14'h0, r_mask}, {16'(r_len), r_base}, int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
